// File: rtl/i2s_tx.sv
// Master-mode I2S transmitter: one mono sample per frame, sent in both slots, BCLK/LRCLK derived from clk.
// Define I2S_TX_LEFT_JUSTIFIED_EN for left-justified framing (no 1-bit data delay); default is standard I2S.
module i2s_tx #(
    parameter int unsigned CLK_DIV      = 16,
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned SLOT_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    samp_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    output logic                    bclk,
    output logic                    lrclk,
    output logic                    sdata,
    output logic                    frame_strobe,
    output logic                    underrun
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(2 * SLOT_WIDTH);
    localparam int unsigned K_W   = $clog2(SLOT_WIDTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_WIDTH);

    logic [DIV_W-1:0]        div_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [SAMPLE_WIDTH-1:0] hold;
    logic [SAMPLE_WIDTH-1:0] frame_buf;
    logic                    fresh;
    logic                    primed;

    logic                    div_wrap;
    logic                    fall_evt;
    logic                    frame_start;
    logic [BIT_W-1:0]        bit_next;
    logic [BIT_W-1:0]        slot_pos;
    logic [K_W-1:0]          k_next;
    logic [SAMPLE_WIDTH-1:0] buf_next;
    logic                    lrclk_next;
    logic                    sdata_next;

    // Next bit position and the data bit it carries; buf_next lets slot 0 see the freshly latched sample.
    always_comb begin
        div_wrap    = (div_cnt == DIV_LAST);
        fall_evt    = div_wrap && bclk;
        frame_start = fall_evt && (bit_cnt == BIT_LAST);
        bit_next    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
        buf_next    = frame_start ? hold : frame_buf;
        slot_pos    = (bit_next >= SLOT_LEN) ? bit_next - SLOT_LEN : bit_next;
        k_next      = K_W'(slot_pos);
        lrclk_next  = (bit_next >= SLOT_LEN);
        sdata_next  = 1'b0;
        for (int unsigned i = 0; i < SAMPLE_WIDTH; i++) begin
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
            if (k_next == K_W'(SAMPLE_WIDTH - 1 - i)) begin
                sdata_next = buf_next[i];
            end
`else
            if (k_next == K_W'(SAMPLE_WIDTH - i)) begin
                sdata_next = buf_next[i];
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt      <= '0;
            bit_cnt      <= '0;
            hold         <= '0;
            frame_buf    <= '0;
            fresh        <= 1'b0;
            primed       <= 1'b0;
            bclk         <= 1'b0;
            lrclk        <= 1'b0;
            sdata        <= 1'b0;
            frame_strobe <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            frame_strobe <= 1'b0;
            if (div_wrap) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (fall_evt) begin
                bit_cnt <= bit_next;
                lrclk   <= lrclk_next;
                sdata   <= sdata_next;
            end
            // The power-up frame has no predecessor, so it never counts as an underrun.
            if (frame_start) begin
                frame_buf    <= hold;
                frame_strobe <= 1'b1;
                primed       <= 1'b1;
                if (!fresh && primed) begin
                    underrun <= 1'b1;
                end
            end
            // A write coinciding with a frame start stays pending for the following frame.
            if (samp_valid) begin
                hold  <= sample_in;
                fresh <= 1'b1;
            end else if (frame_start) begin
                fresh <= 1'b0;
            end
        end
    end

endmodule
